// File: rtl/pc_fetch_queue.sv
// Sequential-PC instruction fetch unit with a DEPTH-entry queue toward IF/ID.
// Handshake: out_valid_o/out_ready_i transfer on any cycle both are high; the head is held stable until accepted.
module pc_fetch_queue #(
  parameter int              DATA_WIDTH = 64,
  parameter int              INST_WIDTH = 32,
  parameter int              DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  input  logic                  imem_err_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_pc_o,
  output logic [INST_WIDTH-1:0] out_inst_o,
  output logic                  out_err_o,
  output logic [1:0]            state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] inflight_pc_q;
  logic                  fault_pend_q;
  logic [CW-1:0]         count_q;
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;

  logic [DATA_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic                  err_mem  [DEPTH];

  logic                  pop, push, req, redirect_act, misaligned, rsp_err;
  logic [CW-1:0]         occ;
  logic [DATA_WIDTH-1:0] push_pc;
  logic [INST_WIDTH-1:0] push_inst;
  logic                  push_err;

  assign out_valid_o  = (count_q != '0);
  assign pop          = out_valid_o & out_ready_i;
  assign redirect_act = redirect_i & (state_q != IDLE);
  assign misaligned   = (redirect_pc_i[1:0] != 2'b00);
  assign rsp_err      = inflight_q & imem_err_i;
  assign occ          = count_q + CW'(inflight_q) - CW'(pop);

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    push      = 1'b0;
    push_pc   = inflight_pc_q;
    push_inst = '0;
    push_err  = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        // A faulting response halts fetch in the same cycle, so nothing is issued past it.
        if (!redirect_i && !rsp_err && (occ < CW'(DEPTH))) req = 1'b1;
        if (rsp_err) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (redirect_act) state_d = misaligned ? HALT : RUN;

    // Responses arriving in a redirect cycle belong to the discarded path.
    if (inflight_q && !redirect_act) begin
      push      = 1'b1;
      push_pc   = inflight_pc_q;
      push_inst = imem_err_i ? '0 : imem_rdata_i;
      push_err  = imem_err_i;
    end else if (fault_pend_q && !redirect_act) begin
      push      = 1'b1;
      push_pc   = pc_q;
      push_inst = '0;
      push_err  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= req;
      fault_pend_q <= redirect_act & misaligned;
      if (req) inflight_pc_q <= pc_q;
      if (redirect_act)  pc_q <= redirect_pc_i;
      else if (req)      pc_q <= pc_q + DATA_WIDTH'(4);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect_act) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_q + CW'(push) - CW'(pop);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      wr_ptr_q <= wr_ptr_q + PW'(push);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
        err_mem[i]  <= 1'b0;
      end
    end else if (push) begin
      pc_mem[wr_ptr_q]   <= push_pc;
      inst_mem[wr_ptr_q] <= push_inst;
      err_mem[wr_ptr_q]  <= push_err;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr_q]   : '0;
  assign out_inst_o  = out_valid_o ? inst_mem[rd_ptr_q] : '0;
  assign out_err_o   = out_valid_o ? err_mem[rd_ptr_q]  : 1'b0;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Bench for pc_fetch_queue: memory model answers rdata = addr[31:0]; a scoreboard predicts the output stream.
module tb_pc_fetch_queue;

  localparam int          DW       = 64;
  localparam int          IW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          EW       = DW + IW + 1;

  logic          clk_i;
  logic          rst_i;
  logic          redirect_i;
  logic [DW-1:0] redirect_pc_i;
  logic          imem_req_o;
  logic [DW-1:0] imem_addr_o;
  logic [IW-1:0] imem_rdata_i;
  logic          imem_err_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_pc_o;
  logic [IW-1:0] out_inst_o;
  logic          out_err_o;
  logic [1:0]    state_o;

  pc_fetch_queue #(
    .DATA_WIDTH(DW), .INST_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_inst_o(out_inst_o), .out_err_o(out_err_o),
    .state_o(state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard and memory model state
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] exp_pc = RESET_PC;
  logic          rsp_pend = 1'b0;
  logic [DW-1:0] rsp_addr = '0;
  logic          hold_vld = 1'b0;
  logic [EW-1:0] hold_val = '0;
  int            req_cnt  = 0;
  int            xfer_cnt = 0;
  logic          err_en   = 1'b0;
  logic [DW-1:0] err_addr = '0;

  always @(posedge clk_i) begin
    #1;
    imem_rdata_i = rsp_pend ? rsp_addr[31:0] : '0;
    imem_err_i   = rsp_pend && err_en && (rsp_addr == err_addr);
  end

  always @(negedge clk_i) begin
    logic [EW-1:0] e;
    if (!rst_i) begin
      exp_q.delete();
      exp_pc   = RESET_PC;
      rsp_pend = 1'b0;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("hold_valid", 128'(out_valid_o), 128'(1));
        check("hold_head", 128'({out_pc_o, out_inst_o, out_err_o}), 128'(hold_val));
      end
      if (out_valid_o && out_ready_i) begin
        xfer_cnt++;
        check("sb_has_entry", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_entry", 128'({out_pc_o, out_inst_o, out_err_o}), 128'(e));
        end
      end
      if (redirect_i) begin
        check("req_on_redirect", 128'(imem_req_o), 128'(0));
        exp_q.delete();
        exp_pc = redirect_pc_i;
        if (redirect_pc_i[1:0] != 2'b00) exp_q.push_back({redirect_pc_i, 32'h0, 1'b1});
      end else if (rsp_pend) begin
        if (imem_err_i) exp_q.push_back({rsp_addr, 32'h0, 1'b1});
        else            exp_q.push_back({rsp_addr, rsp_addr[31:0], 1'b0});
      end
      if (imem_req_o) begin
        req_cnt++;
        check("req_addr", 128'(imem_addr_o), 128'(exp_pc));
        exp_pc = exp_pc + 64'd4;
      end
      rsp_pend = imem_req_o;
      rsp_addr = imem_addr_o;
      hold_vld = out_valid_o && !out_ready_i && !redirect_i;
      hold_val = {out_pc_o, out_inst_o, out_err_o};
    end
  end

  // driver tasks: each returns 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  task automatic do_redirect(input logic [DW-1:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    tick();
    redirect_i    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(out_valid_o), 128'(0));
    check({tag, "_req"},   128'(imem_req_o),  128'(0));
    check({tag, "_head"},  128'({out_pc_o, out_inst_o, out_err_o}), 128'(0));
    check({tag, "_addr"},  128'(imem_addr_o), 128'(RESET_PC));
    check({tag, "_state"}, 128'(state_o),     128'(0));
  endtask

  initial begin
    int r0;
    int xs;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    out_ready_i   = 1'b1;
    imem_rdata_i  = '0;
    imem_err_i    = 1'b0;
    rst_i         = 1'b1;
    #1 rst_i = 1'b0;
    #1 check_reset_outputs("por");

    // startup latency and full-rate streaming
    tick();
    tick();
    rst_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check($sformatf("lat_req_c%0d", k),   128'(imem_req_o),  128'(k >= 1));
      check($sformatf("lat_valid_c%0d", k), 128'(out_valid_o), 128'(k == 3));
    end
    tick();
    xs = xfer_cnt;
    repeat (16) tick();
    check("stream_rate", 128'(xfer_cnt - xs), 128'(16));

    // back-pressure from cycle 0: exactly DEPTH requests, then resume without gaps
    out_ready_i = 1'b0;
    apply_reset();
    r0 = req_cnt;
    repeat (10) tick();
    check("bp_req_count", 128'(req_cnt - r0), 128'(DEPTH));
    check("bp_req_off",   128'(imem_req_o),   128'(0));
    check("bp_head_pc",   128'(out_pc_o),     128'(RESET_PC));
    out_ready_i = 1'b1;
    xs = xfer_cnt;
    repeat (12) tick();
    check("bp_resume_rate", 128'(xfer_cnt - xs), 128'(12));

    // redirect with 3 queued entries and 1 inflight
    out_ready_i = 1'b0;
    apply_reset();
    repeat (5) tick();
    check("pre_redir_valid", 128'(out_valid_o), 128'(1));
    do_redirect(64'h8000_0100);
    check("redir_flushed", 128'(out_valid_o), 128'(0));
    out_ready_i = 1'b1;
    repeat (6) tick();

    // access fault on 0x8000_0008
    err_en   = 1'b1;
    err_addr = 64'h8000_0008;
    apply_reset();
    r0 = req_cnt;
    repeat (12) tick();
    check("fault_req_count", 128'(req_cnt - r0),   128'(3));
    check("fault_state",     128'(state_o),        128'(2));
    check("fault_drained",   128'(exp_q.size()),   128'(0));
    err_en = 1'b0;
    r0 = req_cnt;
    do_redirect(64'h8000_0200);
    repeat (6) tick();
    check("fault_resume_reqs",  128'(req_cnt - r0), 128'(6));
    check("fault_resume_state", 128'(state_o),      128'(1));

    // misaligned redirect
    r0 = req_cnt;
    do_redirect(64'h8000_0102);
    repeat (8) tick();
    check("misal_no_req",  128'(req_cnt - r0),  128'(0));
    check("misal_state",   128'(state_o),       128'(2));
    check("misal_drained", 128'(exp_q.size()),  128'(0));
    r0 = req_cnt;
    do_redirect(64'h8000_0200);
    repeat (6) tick();
    check("misal_resume_reqs", 128'(req_cnt - r0), 128'(6));

    // random back-pressure with occasional aligned redirects
    for (int i = 0; i < 300; i++) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0)
        do_redirect(64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4);
      else
        tick();
    end
    out_ready_i = 1'b1;
    do_redirect(64'h8000_0401);
    repeat (8) tick();
    check("rand_drained", 128'(exp_q.size()), 128'(0));
    check("rand_empty",   128'(out_valid_o),  128'(0));

    // asynchronous reset mid-stream
    do_redirect(64'h8000_0300);
    repeat (4) tick();
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    #1 check_reset_outputs("async");
    tick();
    rst_i = 1'b1;
    r0 = req_cnt;
    repeat (3) tick();
    check("async_restart_reqs", 128'(req_cnt - r0), 128'(2));
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_queue.md
PC_FETCH_QUEUE -- requirements
Module: pc_fetch_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 64, is the PC/address width.
REQ-002 Parameter INST_WIDTH, default 32, is the instruction width.
REQ-003 Parameter DEPTH, default 4, is the instruction queue entries; power of 2, >=2.
REQ-004 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address.
REQ-005 clk_i  in  1  sole clock; all state updates on posedge.
REQ-006 rst_i  in  1  reset, asynchronous, active-low.
REQ-007 redirect_i  in  1  flush queue and restart fetch at redirect_pc_i (branch mispredict/exception).
REQ-008 redirect_pc_i  in  DATA_WIDTH  redirect target.
REQ-009 imem_req_o  out  1  fetch request this cycle; always accepted by memory.
REQ-010 imem_addr_o  out  DATA_WIDTH  fetch address.
REQ-011 imem_rdata_i  in  INST_WIDTH  instruction, valid exactly 1 cycle after the accepted request.
REQ-012 imem_err_i  in  1  access fault, same timing as imem_rdata_i.
REQ-013 out_valid_o  out  1  queue head valid toward IF/ID.
REQ-014 out_ready_i  in  1  consumer accepts head; transfer = out_valid_o & out_ready_i.
REQ-015 out_pc_o  out  DATA_WIDTH  head PC.
REQ-016 out_inst_o  out  INST_WIDTH  head instruction.
REQ-017 out_err_o  out  1  head is a fetch-fault entry.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and HALT; reset enters IDLE, and IDLE goes to RUN after exactly one cycle.
REQ-019 The block SHALL hold pc_q; imem_addr_o = pc_q; each issued request SHALL advance pc_q by 4 modulo 2^DATA_WIDTH, so 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-020 In RUN, imem_req_o SHALL be 1 iff !redirect_i and (count + inflight - pop) < DEPTH, where pop = transfer.
REQ-021 An issued request SHALL set inflight and latch its PC; the next cycle's response SHALL be written to the queue tail with {pc, rdata, err} unless killed.
REQ-022 out_* SHALL be driven from queue head registers only, with no combinational path from any input.
REQ-023 Push and pop in the same cycle SHALL be supported, with count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-024 A response with imem_err_i=1 SHALL be enqueued with err=1 and inst=0; the FSM SHALL enter HALT and issue no requests.
REQ-025 On redirect_i: a transfer in that cycle SHALL complete; all remaining entries SHALL be discarded; the inflight response arriving next cycle SHALL be dropped; pc_q <= redirect_pc_i; imem_req_o=0 that cycle.
REQ-026 A redirect to an aligned target from any non-IDLE state SHALL enter RUN.
REQ-027 A redirect with redirect_pc_i[1:0]!=0 SHALL enter HALT, issue no memory request, and enqueue one entry {pc=redirect_pc_i, inst=0, err=1} on the next cycle.
REQ-028 In HALT, the block SHALL only drain the queue; only redirect_i leaves HALT.
REQ-029 Latency: reset release at cycle 0 (IDLE) -> request for RESET_PC in cycle 1 -> rdata in cycle 2 -> out_valid_o=1 in cycle 3.
REQ-030 Sustained throughput SHALL be 1 instruction/cycle while out_ready_i=1.
REQ-031 With out_ready_i=0, requests SHALL stop when count+inflight==DEPTH; no response SHALL ever be dropped except by redirect.
REQ-032 While out_ready_i=0, out_pc_o, out_inst_o and out_err_o SHALL be held stable while out_valid_o=1.

Reset
REQ-033 On rst_i=0 (async): state=IDLE, pc_q=RESET_PC, count=0, pointers=0, inflight=0, out_valid_o=0, imem_req_o=0, out_pc_o=0, out_inst_o=0, out_err_o=0.
REQ-034 A reset asserted mid-fetch SHALL discard the queue and inflight response; the first request after release SHALL be to RESET_PC.

Verification
REQ-035 Release reset, out_ready_i=1, rdata=addr[31:0] -> requests 0x8000_0000, 0x8000_0004, ...; out_valid_o rises cycle 3; one transfer/cycle, PCs consecutive.
REQ-036 out_ready_i=0 from cycle 0 -> exactly 4 requests issued, count=4, imem_req_o=0; head stable at PC 0x8000_0000; ready=1 resumes with no gap or loss.
REQ-037 Redirect to 0x8000_0100 while queue holds 3 entries and 1 inflight -> queue empty next cycle, inflight data never appears, next request 0x8000_0100, next output PC 0x8000_0100.
REQ-038 imem_err_i=1 on fetch of 0x8000_0008 -> entries 0x8000_0000, 0x8000_0004, then {0x8000_0008, 0, err=1}; no further requests until redirect.
REQ-039 Redirect to 0x8000_0102 -> no memory request; single entry pc=0x8000_0102, err=1; HALT; later redirect to 0x8000_0200 resumes fetch.
REQ-040 Assert rst_i=0 mid-stream between clock edges -> outputs reach reset values immediately; after release, first request is 0x8000_0000.
